// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared codes, FSM states and helpers for the snake body engine
// Exports: dir_t, obj_t, state_t, game-status codes, opposite_dir().
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        OBJ_NONE = 2'b00,
        OBJ_HEAD = 2'b01,
        OBJ_BODY = 2'b10,
        OBJ_WALL = 2'b11
    } obj_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    localparam logic [2:0] GS_START = 3'b001;
    localparam logic [2:0] GS_PLAY  = 3'b010;
    localparam logic [2:0] GS_END   = 3'b100;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// rtl/snake_dir_fifo.sv - depth-2 direction command queue with same/reverse filter
// Ports: clk_i, rst_n_i (async, active-low), flush_i, push_i/push_dir_i,
//        pop_i, cur_dir_i (reference when empty), head_dir_o, empty_o, full_o.
module snake_dir_fifo
    import snake_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic flush_i,
    input  logic push_i,
    input  dir_t push_dir_i,
    input  logic pop_i,
    input  dir_t cur_dir_i,
    output dir_t head_dir_o,
    output logic empty_o,
    output logic full_o
);

    dir_t       mem_q [2];
    dir_t       mem_d [2];
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic [1:0] cnt_pop;
    logic       do_pop;
    logic       accept;
    dir_t       ref_dir;

    always_comb begin
        // A new command is judged against the newest queued command, so a
        // push in the pop cycle still sees the direction it will follow.
        ref_dir = cur_dir_i;
        if (cnt_q == 2'd1) begin
            ref_dir = mem_q[0];
        end else if (cnt_q == 2'd2) begin
            ref_dir = mem_q[1];
        end

        do_pop  = pop_i && (cnt_q != 2'd0);
        cnt_pop = do_pop ? cnt_q - 2'd1 : cnt_q;
        accept  = push_i && (cnt_pop != 2'd2) &&
                  (push_dir_i != ref_dir) && (push_dir_i != opposite_dir(ref_dir));

        mem_d = mem_q;
        if (do_pop) begin
            mem_d[0] = mem_q[1];
        end
        cnt_d = cnt_pop;
        if (accept) begin
            mem_d[cnt_pop[0]] = push_dir_i;
            cnt_d             = cnt_pop + 2'd1;
        end
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q    <= 2'd0;
            mem_q[0] <= DIR_RIGHT;
            mem_q[1] <= DIR_RIGHT;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign head_dir_o = mem_q[0];
    assign empty_o    = (cnt_q == 2'd0);
    assign full_o     = (cnt_q == 2'd2);

endmodule

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - snake movement, growth, collision and pixel classification
// Inputs : Clk_50mhz, Rst_n (async, active-low), Key_left/right/up/down pulses,
//          Game_status[2:0], Body_add_sig, Flash_sig, Pixel_x/Pixel_y[9:0].
// Outputs: Object[1:0] (registered), Head_x/Head_y[5:0], Body_len[6:0],
//          Step_pulse, Hit_wall_sig, Hit_body_sig.
// Build option: SNAKE_WRAP_EN makes the head wrap across the interior instead of dying.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int MAX_LEN     = 32,
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int CELL_SHIFT  = 4,
    parameter int TICK_CYCLES = 12_500_000,
    parameter int INIT_LEN    = 3,
    parameter int INIT_X      = 10,
    parameter int INIT_Y      = 5
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    input  logic       Key_left,
    input  logic       Key_right,
    input  logic       Key_up,
    input  logic       Key_down,
    input  logic [2:0] Game_status,
    input  logic       Body_add_sig,
    input  logic       Flash_sig,
    input  logic [9:0] Pixel_x,
    input  logic [9:0] Pixel_y,
    output logic [1:0] Object,
    output logic [5:0] Head_x,
    output logic [5:0] Head_y,
    output logic [6:0] Body_len,
    output logic       Step_pulse,
    output logic       Hit_wall_sig,
    output logic       Hit_body_sig
);

    localparam logic [5:0]  X_LAST    = 6'(GRID_W - 1);
    localparam logic [5:0]  Y_LAST    = 6'(GRID_H - 1);
    localparam logic [6:0]  LEN_MAX   = 7'(MAX_LEN);
    localparam logic [6:0]  LEN_INIT  = 7'(INIT_LEN);
    localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
`ifdef SNAKE_WRAP_EN
    localparam logic [5:0]  X_INNER   = 6'(GRID_W - 2);
    localparam logic [5:0]  Y_INNER   = 6'(GRID_H - 2);
`endif

    // Segments past INIT_LEN park on the initial tail so growth never exposes junk.
    function automatic logic [5:0] init_x(input int i);
        return (i < INIT_LEN) ? 6'(INIT_X - i) : 6'(INIT_X - INIT_LEN + 1);
    endfunction

    state_t      state_q, state_d;
    logic [31:0] tick_q, tick_d;
    dir_t        cur_dir_q, cur_dir_d;
    logic [5:0]  body_x_q [MAX_LEN];
    logic [5:0]  body_y_q [MAX_LEN];
    logic [5:0]  body_x_d [MAX_LEN];
    logic [5:0]  body_y_d [MAX_LEN];
    logic [6:0]  len_q, len_d;
    logic [1:0]  grow_q, grow_d;
    logic        add_prev_q;
    logic        hit_wall_q, hit_wall_d;
    logic        hit_body_q, hit_body_d;
    logic        step_q;
    obj_t        obj_q, obj_d;

    logic        game_end, game_play, in_run, step_now;
    logic        key_valid;
    dir_t        key_dir;
    dir_t        fifo_head, new_dir;
    logic        fifo_empty, fifo_full;
    logic [5:0]  nx, ny;
    logic        wall_hit, self_hit, growing, collide, move_ok, add_edge;
    logic [9:0]  cell_x, cell_y;
    logic        head_match, body_match, wall_cell;

    assign game_end  = (Game_status == GS_END);
    assign game_play = (Game_status == GS_PLAY);
    assign add_edge  = Body_add_sig && !add_prev_q;

    // FSM: state register
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (game_play) state_d = ST_RUN;
            ST_RUN:  if (collide)   state_d = ST_DEAD;
            ST_DEAD: state_d = ST_DEAD;
            default: state_d = ST_IDLE;
        endcase
        if (game_end) begin
            state_d = ST_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        in_run = 1'b0;
        case (state_q)
            ST_RUN:  in_run = 1'b1;
            default: in_run = 1'b0;
        endcase
    end

    assign step_now = in_run && (tick_q == TICK_LAST) && !game_end;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_LEFT;
        if (Key_left) begin
            key_dir = DIR_LEFT;
        end else if (Key_right) begin
            key_dir = DIR_RIGHT;
        end else if (Key_up) begin
            key_dir = DIR_UP;
        end else if (Key_down) begin
            key_dir = DIR_DOWN;
        end else begin
            key_valid = 1'b0;
        end
    end

    snake_dir_fifo u_dir_fifo (
        .clk_i      (Clk_50mhz),
        .rst_n_i    (Rst_n),
        .flush_i    (game_end),
        .push_i     (key_valid),
        .push_dir_i (key_dir),
        .pop_i      (step_now),
        .cur_dir_i  (cur_dir_q),
        .head_dir_o (fifo_head),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign new_dir = fifo_empty ? cur_dir_q : fifo_head;

    always_comb begin
        nx = body_x_q[0];
        ny = body_y_q[0];
`ifdef SNAKE_WRAP_EN
        case (new_dir)
            DIR_UP:   ny = (body_y_q[0] == 6'd1)    ? Y_INNER : body_y_q[0] - 6'd1;
            DIR_DOWN: ny = (body_y_q[0] == Y_INNER) ? 6'd1    : body_y_q[0] + 6'd1;
            DIR_LEFT: nx = (body_x_q[0] == 6'd1)    ? X_INNER : body_x_q[0] - 6'd1;
            default:  nx = (body_x_q[0] == X_INNER) ? 6'd1    : body_x_q[0] + 6'd1;
        endcase
        wall_hit = 1'b0;
`else
        case (new_dir)
            DIR_UP:   ny = body_y_q[0] - 6'd1;
            DIR_DOWN: ny = body_y_q[0] + 6'd1;
            DIR_LEFT: nx = body_x_q[0] - 6'd1;
            default:  nx = body_x_q[0] + 6'd1;
        endcase
        wall_hit = (nx == 6'd0) || (nx == X_LAST) || (ny == 6'd0) || (ny == Y_LAST);
`endif
    end

    // The tail normally vacates its cell this step, so it only counts as an
    // obstacle when the snake is growing and the tail stays put.
    assign growing = (grow_q != 2'd0) && (len_q < LEN_MAX);

    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (((7'(i) < len_q - 7'd1) || (growing && (7'(i) < len_q))) &&
                (body_x_q[i] == nx) && (body_y_q[i] == ny)) begin
                self_hit = 1'b1;
            end
        end
    end

    assign collide = step_now && (wall_hit || self_hit);
    assign move_ok = step_now && !wall_hit && !self_hit;

    always_comb begin
        tick_d     = 32'd0;
        cur_dir_d  = cur_dir_q;
        len_d      = len_q;
        grow_d     = grow_q;
        hit_wall_d = hit_wall_q;
        hit_body_d = hit_body_q;
        body_x_d   = body_x_q;
        body_y_d   = body_y_q;

        if (in_run && (tick_q != TICK_LAST)) begin
            tick_d = tick_q + 32'd1;
        end
        if (step_now) begin
            cur_dir_d = new_dir;
        end
        if (collide) begin
            hit_wall_d = hit_wall_q | wall_hit;
            hit_body_d = hit_body_q | (self_hit && !wall_hit);
        end
        if (move_ok) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                body_x_d[i] = body_x_q[i-1];
                body_y_d[i] = body_y_q[i-1];
            end
            body_x_d[0] = nx;
            body_y_d[0] = ny;
            if (growing) begin
                len_d  = len_q + 7'd1;
                grow_d = grow_q - 2'd1;
            end
        end
        if (add_edge && (grow_d != 2'd3)) begin
            grow_d = grow_d + 2'd1;
        end
        if (len_q == LEN_MAX) begin
            grow_d = 2'd0;
        end

        if (game_end) begin
            tick_d     = 32'd0;
            cur_dir_d  = DIR_RIGHT;
            len_d      = LEN_INIT;
            grow_d     = 2'd0;
            hit_wall_d = 1'b0;
            hit_body_d = 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_d[i] = init_x(i);
                body_y_d[i] = 6'(INIT_Y);
            end
        end
    end

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            tick_q     <= 32'd0;
            cur_dir_q  <= DIR_RIGHT;
            len_q      <= LEN_INIT;
            grow_q     <= 2'd0;
            add_prev_q <= 1'b0;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
            step_q     <= 1'b0;
            obj_q      <= OBJ_NONE;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_x_q[i] <= init_x(i);
                body_y_q[i] <= 6'(INIT_Y);
            end
        end else begin
            tick_q     <= tick_d;
            cur_dir_q  <= cur_dir_d;
            len_q      <= len_d;
            grow_q     <= grow_d;
            add_prev_q <= Body_add_sig;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
            step_q     <= move_ok;
            obj_q      <= obj_d;
            body_x_q   <= body_x_d;
            body_y_q   <= body_y_d;
        end
    end

    assign cell_x = Pixel_x >> CELL_SHIFT;
    assign cell_y = Pixel_y >> CELL_SHIFT;

    always_comb begin
        wall_cell  = (cell_x == 10'd0) || (cell_x == 10'(X_LAST)) ||
                     (cell_y == 10'd0) || (cell_y == 10'(Y_LAST));
        head_match = (cell_x == 10'(body_x_q[0])) && (cell_y == 10'(body_y_q[0]));
        body_match = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((7'(i) < len_q) && (cell_x == 10'(body_x_q[i])) &&
                (cell_y == 10'(body_y_q[i]))) begin
                body_match = 1'b1;
            end
        end

        obj_d = OBJ_NONE;
        if ((Pixel_x >= 10'd640) || (Pixel_y >= 10'd480)) begin
            obj_d = OBJ_NONE;
        end else if (wall_cell) begin
            obj_d = OBJ_WALL;
        end else if (head_match) begin
            obj_d = Flash_sig ? OBJ_HEAD : OBJ_NONE;
        end else if (body_match) begin
            obj_d = Flash_sig ? OBJ_BODY : OBJ_NONE;
        end
    end

    assign Object       = obj_q;
    assign Head_x       = body_x_q[0];
    assign Head_y       = body_y_q[0];
    assign Body_len     = len_q;
    assign Step_pulse   = step_q;
    assign Hit_wall_sig = hit_wall_q;
    assign Hit_body_sig = hit_body_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - self-checking bench for snake_body_engine
module tb_snake_body_engine;
    import snake_pkg::*;

    localparam int TICKS = 4;
    localparam int MAXL  = 6;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       k_left = 1'b0, k_right = 1'b0, k_up = 1'b0, k_down = 1'b0;
    logic [2:0] status = GS_START;
    logic       add_sig = 1'b0;
    logic       flash = 1'b1;
    logic [9:0] px = 10'd0, py = 10'd0;
    logic [1:0] object;
    logic [5:0] head_x, head_y;
    logic [6:0] body_len;
    logic       step_pulse, hit_wall, hit_body;

    snake_body_engine #(
        .MAX_LEN     (MAXL),
        .TICK_CYCLES (TICKS)
    ) dut (
        .Clk_50mhz    (clk),
        .Rst_n        (rstn),
        .Key_left     (k_left),
        .Key_right    (k_right),
        .Key_up       (k_up),
        .Key_down     (k_down),
        .Game_status  (status),
        .Body_add_sig (add_sig),
        .Flash_sig    (flash),
        .Pixel_x      (px),
        .Pixel_y      (py),
        .Object       (object),
        .Head_x       (head_x),
        .Head_y       (head_y),
        .Body_len     (body_len),
        .Step_pulse   (step_pulse),
        .Hit_wall_sig (hit_wall),
        .Hit_body_sig (hit_body)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       fl;
        logic [1:0] obj;
    } pix_vec_t;

    typedef struct {
        int x;
        int y;
        int len;
    } step_exp_t;

    pix_vec_t  vecs [14];
    step_exp_t step_q [$];
    logic [1:0] obj_q [$];
    int n_vec = 0;
    int n_bad = 0;
    int ex, ey, elen;
    int gap;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic probe(input string name, input logic [9:0] x, input logic [9:0] y,
                         input logic fl, input logic [1:0] exp);
        px = x;
        py = y;
        flash = fl;
        obj_q.push_back(exp);
        tick();
        check(name, int'(object), int'(obj_q.pop_front()));
    endtask

    task automatic expect_move(input dir_t d, input bit grow);
        step_exp_t e;
        case (d)
            DIR_UP:   ey--;
            DIR_DOWN: ey++;
            DIR_LEFT: ex--;
            default:  ex++;
        endcase
        if (grow) elen++;
        e.x = ex;
        e.y = ey;
        e.len = elen;
        step_q.push_back(e);
    endtask

    task automatic wait_step(input string name);
        step_exp_t e;
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 20);
        gap = n;
        e = step_q.pop_front();
        if (!step_pulse) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: no Step_pulse within 20 cycles", name);
        end else begin
            check({name, "_x"}, int'(head_x), e.x);
            check({name, "_y"}, int'(head_y), e.y);
            check({name, "_len"}, int'(body_len), e.len);
        end
    endtask

    task automatic key(input dir_t d);
        case (d)
            DIR_LEFT:  k_left = 1'b1;
            DIR_RIGHT: k_right = 1'b1;
            DIR_UP:    k_up = 1'b1;
            default:   k_down = 1'b1;
        endcase
        tick();
        k_left = 1'b0;
        k_right = 1'b0;
        k_up = 1'b0;
        k_down = 1'b0;
    endtask

    task automatic expect_no_step(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (step_pulse) seen++;
        end
        check(name, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{10'd160, 10'd80,  1'b1, OBJ_HEAD};
        vecs[1]  = '{10'd175, 10'd95,  1'b1, OBJ_HEAD};
        vecs[2]  = '{10'd144, 10'd80,  1'b1, OBJ_BODY};
        vecs[3]  = '{10'd128, 10'd80,  1'b1, OBJ_BODY};
        vecs[4]  = '{10'd112, 10'd80,  1'b1, OBJ_NONE};
        vecs[5]  = '{10'd0,   10'd0,   1'b1, OBJ_WALL};
        vecs[6]  = '{10'd639, 10'd479, 1'b1, OBJ_WALL};
        vecs[7]  = '{10'd640, 10'd100, 1'b1, OBJ_NONE};
        vecs[8]  = '{10'd100, 10'd480, 1'b1, OBJ_NONE};
        vecs[9]  = '{10'd160, 10'd80,  1'b0, OBJ_NONE};
        vecs[10] = '{10'd144, 10'd80,  1'b0, OBJ_NONE};
        vecs[11] = '{10'd0,   10'd200, 1'b0, OBJ_WALL};
        vecs[12] = '{10'd320, 10'd240, 1'b1, OBJ_NONE};
        vecs[13] = '{10'd16,  10'd16,  1'b1, OBJ_NONE};

        // Reset state, sampled while reset is still asserted
        tick();
        tick();
        check("rst_object", int'(object), 0);
        check("rst_hit_wall", int'(hit_wall), 0);
        check("rst_hit_body", int'(hit_body), 0);
        check("rst_step", int'(step_pulse), 0);
        check("rst_head_x", int'(head_x), 10);
        check("rst_head_y", int'(head_y), 5);
        check("rst_len", int'(body_len), 3);
        rstn = 1'b1;
        tick();

        // Pixel classification table on the initial body
        for (int i = 0; i < 14; i++) begin
            probe($sformatf("pix_vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].fl, vecs[i].obj);
        end
        flash = 1'b1;

        // Straight run, no keys
        ex = 10; ey = 5; elen = 3;
        status = GS_PLAY;
        expect_move(DIR_RIGHT, 0);
        expect_move(DIR_RIGHT, 0);
        wait_step("run1");
        wait_step("run2");
        check("step_gap", gap, TICKS);

        // Reverse press discarded, up applied
        key(DIR_LEFT);
        key(DIR_UP);
        expect_move(DIR_UP, 0);
        wait_step("turn_up1");
        expect_move(DIR_UP, 0);
        wait_step("turn_up2");

        // Queue full: third press dropped
        key(DIR_RIGHT);
        key(DIR_DOWN);
        key(DIR_LEFT);
        expect_move(DIR_RIGHT, 0);
        expect_move(DIR_DOWN, 0);
        expect_move(DIR_DOWN, 0);
        wait_step("q_right");
        wait_step("q_down");
        wait_step("q_keep_down");

        // Two growth edges within one tick; tail cell (13,3) kept
        add_sig = 1'b1; tick();
        add_sig = 1'b0; tick();
        add_sig = 1'b1; tick();
        add_sig = 1'b0;
        expect_move(DIR_DOWN, 1);
        wait_step("grow1");
        probe("tail_kept1", 10'd208, 10'd48, 1'b1, OBJ_BODY);
        expect_move(DIR_DOWN, 1);
        wait_step("grow2");
        probe("tail_kept2", 10'd208, 10'd48, 1'b1, OBJ_BODY);
        expect_move(DIR_DOWN, 0);
        wait_step("no_grow");
        probe("tail_moved", 10'd208, 10'd48, 1'b1, OBJ_NONE);

        // Grow to MAX_LEN, then further requests are dropped
        add_sig = 1'b1; tick();
        add_sig = 1'b0;
        expect_move(DIR_DOWN, 1);
        wait_step("grow_max");
        add_sig = 1'b1; tick();
        add_sig = 1'b0;
        expect_move(DIR_DOWN, 0);
        wait_step("max_hold1");
        expect_move(DIR_DOWN, 0);
        wait_step("max_hold2");

        // Run right into the east wall
        key(DIR_RIGHT);
        for (int x = 14; x <= 38; x++) begin
            expect_move(DIR_RIGHT, 0);
            wait_step($sformatf("east_x%0d", x));
        end
`ifdef SNAKE_WRAP_EN
        begin
            step_exp_t e;
            ex = 1;
            e.x = ex; e.y = ey; e.len = elen;
            step_q.push_back(e);
        end
        wait_step("wrap_x1");
        check("wrap_hit_wall", int'(hit_wall), 0);
`else
        expect_no_step("wall_no_step", 12);
        check("wall_hit", int'(hit_wall), 1);
        check("wall_head_x", int'(head_x), 38);
        check("wall_hit_body", int'(hit_body), 0);
        expect_no_step("dead_frozen", 8);
        check("dead_head_x", int'(head_x), 38);
`endif

        // END restores the initial snake
        status = GS_END;
        tick();
        check("end_head_x", int'(head_x), 10);
        check("end_head_y", int'(head_y), 5);
        check("end_len", int'(body_len), 3);
        check("end_hit_wall", int'(hit_wall), 0);
        check("end_hit_body", int'(hit_body), 0);
        probe("end_head_pix", 10'd160, 10'd80, 1'b1, OBJ_HEAD);

        // Grow to 5 then loop down, left, up into own body
        ex = 10; ey = 5; elen = 3;
        status = GS_PLAY;
        add_sig = 1'b1; tick();
        add_sig = 1'b0; tick();
        add_sig = 1'b1; tick();
        add_sig = 1'b0;
        expect_move(DIR_RIGHT, 1);
        wait_step("loop_r1");
        expect_move(DIR_RIGHT, 1);
        wait_step("loop_r2");
        key(DIR_DOWN);
        expect_move(DIR_DOWN, 0);
        wait_step("loop_d");
        key(DIR_LEFT);
        expect_move(DIR_LEFT, 0);
        wait_step("loop_l");
        key(DIR_UP);
        expect_no_step("self_no_step", 12);
        check("self_hit_body", int'(hit_body), 1);
        check("self_hit_wall", int'(hit_wall), 0);
        check("self_head_x", int'(head_x), 11);
        check("self_head_y", int'(head_y), 6);
        check("self_len", int'(body_len), 5);

        status = GS_END;
        tick();
        check("end2_hit_body", int'(hit_body), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Parametrised snake movement and collision engine for the Greedy_snake game, driven by debounced key pulses and the game-status FSM. It owns the body coordinate array, a small direction-command queue, length growth and wall/self collision. It also classifies each VGA pixel as NONE/HEAD/BODY/WALL. It sits between the key debouncers, the apple generator (Body_add_sig) and the VGA colour mux (Object).

## Interface
- MAX_LEN, 32: maximum body segments including the head, 4..64.
- GRID_W, 40: grid columns including the wall ring.
- GRID_H, 30: grid rows including the wall ring.
- CELL_SHIFT, 4: log2 of cell size in pixels; cell = Pixel[9:CELL_SHIFT].
- TICK_CYCLES, 12_500_000: clocks per move step (0.25 s at 50 MHz).
- INIT_LEN, 3: length after reset or END, 2..MAX_LEN.
- INIT_X / INIT_Y, 10 / 5: head start cell; body extends toward -x.
- Clk_50mhz  in  1  system clock.
- Rst_n  in  1  reset, asynchronous, active-low.
- Key_left / Key_right / Key_up / Key_down  in  1 each  single-cycle debounced press pulses.
- Game_status  in  3  001 START, 010 PLAY, 100 END.
- Body_add_sig  in  1  apple-eaten level; each rising edge requests one segment.
- Flash_sig  in  1  blink enable; 0 blanks HEAD/BODY to NONE.
- Pixel_x / Pixel_y  in  10 each  current VGA scan pixel.
- Object  out  2  00 NONE, 01 HEAD, 10 BODY, 11 WALL; registered.
- Head_x / Head_y  out  6 each  head cell.
- Body_len  out  7  current length.
- Step_pulse  out  1  one-cycle strobe on each executed move.
- Hit_wall_sig / Hit_body_sig  out  1 each  sticky collision flags.

## Operation
- FSM states: IDLE, RUN, DEAD.
  - IDLE → RUN when Game_status == PLAY.
  - RUN → DEAD when a collision is detected.
  - Any state → IDLE when Game_status == END.
  - DEAD holds the body frozen.
- END (any cycle, any state) does the following:
  - restores the initial body, direction Right and length INIT_LEN;
  - clears the queue, the grow-pending count and both hit flags;
  - restarts the tick counter.
- Tick counter: counts 0..TICK_CYCLES-1 only in RUN. The wrap cycle is a step; in IDLE/DEAD it is held at 0.
- Direction queue: depth 2.
  - A key pulse is compared against the last queued direction, or the current direction if the queue is empty.
  - Same or opposite direction: discarded. Otherwise it is enqueued.
  - Queue full: discarded.
  - Priority for simultaneous pulses: left > right > up > down; only one is accepted per cycle.
  - At each step, one entry is popped and becomes the current direction before the next head is computed.
- Step sequence:
  1. Compute the next head.
  2. Wall check: next head on row/column 0, GRID_W-1 or GRID_H-1 sets Hit_wall_sig. Position is unchanged and the FSM goes to DEAD.
  3. Self check: next head equal to segment i for any i in 0..Body_len-2 sets Hit_body_sig. If growing this step, the range is 0..Body_len-1. Position is unchanged and the FSM goes to DEAD.
  4. Otherwise shift segments (i ← i-1), load the head and pulse Step_pulse.
- Growth:
  - A Body_add_sig rising edge increments grow_pending, saturating at 3.
  - On a successful step with grow_pending > 0 and Body_len < MAX_LEN: Body_len+1, the tail cell is kept, grow_pending-1.
  - At MAX_LEN, requests are dropped and grow_pending is cleared.
- Pixel classification, in priority order:
  1. Outside 640x480 → NONE.
  2. Wall-ring cell → WALL.
  3. Head cell → HEAD.
  4. Cell of any segment 1..Body_len-1 → BODY.
  5. Else NONE.
  - HEAD/BODY become NONE when Flash_sig = 0.
  - Segments at index ≥ Body_len never match.

## Timing
- Reset values:
  - Object = 00, Hit flags = 0, Step_pulse = 0.
  - Head = (INIT_X, INIT_Y), Body_len = INIT_LEN.
  - Direction Right, queue empty, FSM IDLE.
- Object: registered, 1-cycle latency from Pixel_x/Pixel_y.
- Body/head/flags: update on the step cycle, visible the cycle after.
- Key pulse to direction change: takes effect at the next step; a pulse in the step cycle itself is enqueued after the pop.
- Body_add_sig edge coincident with a step counts toward the following step.
- Rst_n deassertion mid-step: no partial update; the engine restarts from reset state.

## Configuration
- SNAKE_WRAP_EN defined:
  - no wall death; a head leaving cell 1 or cell GRID-2 re-enters at the opposite interior edge;
  - Hit_wall_sig is tied 0;
  - the wall ring is still drawn.
- Undefined: wall collision as specified above.

## Structure
- Shared package snake_pkg holds:
  - direction codes UP 00, DOWN 01, LEFT 10, RIGHT 11;
  - object codes;
  - game-status codes;
  - an opposite-direction function.
- One sub-module: snake_dir_fifo.
  - Depth-2 queue with reverse/duplicate filter.
  - Ports: push dir, pop, flush, head dir, empty, full.

## Test plan
- Reset, PLAY, TICK_CYCLES=4, no keys → head (11,5),(12,5) after 2 steps; Step_pulse every 4 cycles; Body_len 3.
- From Right, pulse Key_left then Key_up → left discarded; up applied next step; head y decrements.
- Pulse up, left, down before one step → queue holds up, left; down dropped (full); head moves up, then left.
- Body_add_sig two edges within one tick → Body_len 3→4→5 over two steps; tail cell retained each time; at MAX_LEN no further growth.
- Head at x=38 moving right → Hit_wall_sig=1, head stays 38, FSM DEAD. With SNAKE_WRAP_EN the head goes to x=1 with no hit.
- Length-5 loop (right, down, left, up) → Hit_body_sig=1. Then END → head (10,5), Body_len 3, flags 0; pixel (160,80) gives Object HEAD one cycle later with Flash_sig=1.
